squared_pipe: RTL and testbench
===============================

Name: squared_pipe

Overview:
- Parametrised, pipelined squaring stage for the Pan-Tompkins QRS chain; sits between the derivative filter and the moving-window integrator.
- Accepts signed or unsigned samples and returns a scaled, optionally rounded, saturated square.
- Uses a valid/ready handshake with backpressure and keeps a saturation statistics counter.

Parameters:
- DATA_WIDTH, 11, input sample width.
- OUT_WIDTH, 11, output sample width.
- SHIFT, 9, right shift applied to the full-precision square (0..2*DATA_WIDTH-1).
- PIPE_STAGES, 2, input-to-output latency in cycles when not stalled (legal 1..4).
- SIGNED_IN, 1, 1 = in_data is two's complement, 0 = unsigned.
- CNT_WIDTH, 16, width of sat_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_WIDTH  sample.
- round_en  input  1  1 = round half-up before the shift, 0 = truncate; sampled with each accepted input.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OUT_WIDTH  scaled square.
- out_sat  output  1  out_data was clamped; qualified by out_valid.
- clr_stats  input  1  synchronous clear of sat_count.
- sat_count  output  CNT_WIDTH  number of saturated samples delivered.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valids are 0, out_valid=0, out_data=0, out_sat=0, sat_count=0. In-flight samples are discarded. in_ready is 0 while rst=1.
- Advance enable: adv = !out_valid || out_ready.
  - in_ready = adv && !rst.
  - An input transfer occurs when in_valid && in_ready.
  - When adv=0, every stage, valid bit and output holds.
- Pipeline: a valid bit travels with each sample through PIPE_STAGES registers. Bubbles propagate as valid=0. Latency from accept edge to out_valid is exactly PIPE_STAGES cycles when unstalled. Throughput is 1 sample/cycle.
- Arithmetic:
  - Magnitude m = |in_data| when SIGNED_IN=1, else in_data.
  - In signed mode, the most negative value gives m = 2^(DATA_WIDTH-1); magnitude width is DATA_WIDTH bits.
  - p = m*m, full precision, 2*DATA_WIDTH bits, no truncation.
  - If round_en=1 and SHIFT>0: q = (p + 2^(SHIFT-1)) >> SHIFT, computed one bit wider than p so the add cannot overflow. Otherwise q = p >> SHIFT.
  - If q > 2^OUT_WIDTH - 1: out_data = 2^OUT_WIDTH - 1 and out_sat = 1. Otherwise out_data = q[OUT_WIDTH-1:0] and out_sat = 0.
  - Output is always non-negative; there is no enable-gating of out_data.
- Stage split (implementer's choice): magnitude in stage 1, multiply in the remaining stages, round/shift/saturate combined into the last stage. The last stage is registered.
- Output stability: out_data and out_sat hold constant while out_valid && !out_ready.
- sat_count:
  - Increments by 1 on each output transfer (out_valid && out_ready) with out_sat=1.
  - Sticks at 2^CNT_WIDTH - 1; no wrap.
  - clr_stats=1 sets it to 0, and clear wins over a simultaneous increment.
  - rst clears it.
- Boundaries:
  - Stall with a full pipeline loses no sample.
  - in_valid held low produces bubbles only; out_valid drops PIPE_STAGES cycles later.
  - rst asserted mid-stall flushes everything on the next edge.

Test Plan:
1. Defaults, signed, round_en=0, out_ready=1, in_data = 100, -100, 0, 1023 back-to-back -> out_data 19, 19, 0, 2044 on consecutive cycles starting 2 cycles after the first accept, out_sat=0.
2. round_en=1, in_data=100 -> out_data 20; in_data=-1024 -> p=1048576, q=2048, out_data 2047, out_sat=1, sat_count=1.
3. SIGNED_IN=0, in_data=2047 -> q=8184, out_data 2047, out_sat=1; in_data=22 -> 484>>9 = 0, out_sat=0.
4. Backpressure: stream 8 samples with out_ready toggling 1,0,0,1,... -> in_ready tracks adv, all 8 squares delivered in order, outputs held stable while stalled, no duplicates.
5. sat_count: CNT_WIDTH=2, deliver 5 saturating samples -> count 1,2,3,3,3. Then clr_stats in the same cycle as a saturated transfer -> sat_count 0.
6. Assert rst for 1 cycle with 2 samples in flight and out_ready=0 -> next cycle out_valid=0, out_data=0, sat_count=0. A new sample after rst deasserts emerges after PIPE_STAGES cycles.

Source files
------------

// File: rtl/squared_pipe.sv
// squared_pipe: pipelined magnitude-square stage with round, shift and saturate.
// Valid/ready handshake with full-pipeline stall and a sticky saturation counter.
module squared_pipe #(
  parameter int DATA_WIDTH  = 11,
  parameter int OUT_WIDTH   = 11,
  parameter int SHIFT       = 9,
  parameter int PIPE_STAGES = 2,
  parameter bit SIGNED_IN   = 1'b1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  round_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  sat_count
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int QW = PW + 1;
  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [QW-1:0] HALF =
    (SHIFT > 0) ? (QW'(1) << HS) : '0;

  logic                   adv;
  logic                   xfer_in;
  logic [PIPE_STAGES-1:0] vld;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !rst;
  assign xfer_in   = in_valid && in_ready;
  assign out_valid = vld[PIPE_STAGES-1];

  function automatic logic [DATA_WIDTH-1:0] mag(
    input logic [DATA_WIDTH-1:0] x
  );
    if (SIGNED_IN && x[DATA_WIDTH-1]) return -x;
    else return x;
  endfunction

  function automatic logic [PW-1:0] sq(
    input logic [DATA_WIDTH-1:0] m
  );
    return {{DATA_WIDTH{1'b0}}, m} * {{DATA_WIDTH{1'b0}}, m};
  endfunction

  // {sat, data}; the sum is one bit wider than p so rounding cannot wrap
  function automatic logic [OUT_WIDTH:0] fin(
    input logic [PW-1:0] p,
    input logic          rnd
  );
    logic [QW-1:0]        q;
    logic                 sat;
    logic [OUT_WIDTH-1:0] d;
    q   = ({1'b0, p} + (rnd ? HALF : '0)) >> SHIFT;
    sat = |(q >> OUT_WIDTH);
    d   = sat ? '1 : OUT_WIDTH'(q);
    return {sat, d};
  endfunction

  generate
    if (PIPE_STAGES == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) begin
          vld      <= '0;
          out_sat  <= 1'b0;
          out_data <= '0;
        end else if (adv) begin
          vld                 <= xfer_in;
          {out_sat, out_data} <= fin(sq(mag(in_data)), round_en);
        end
      end
    end else if (PIPE_STAGES == 2) begin : g_two
      logic [DATA_WIDTH-1:0] m_q;
      logic                  r_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld      <= '0;
          m_q      <= '0;
          r_q      <= 1'b0;
          out_sat  <= 1'b0;
          out_data <= '0;
        end else if (adv) begin
          vld                 <= {vld[0], xfer_in};
          m_q                 <= mag(in_data);
          r_q                 <= round_en;
          {out_sat, out_data} <= fin(sq(m_q), r_q);
        end
      end
    end else begin : g_deep
      logic [DATA_WIDTH-1:0] m_q;
      logic                  r_q [PIPE_STAGES-1];
      logic [PW-1:0]         p_q [PIPE_STAGES-2];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld      <= '0;
          m_q      <= '0;
          out_sat  <= 1'b0;
          out_data <= '0;
          for (int k = 0; k < PIPE_STAGES - 1; k++)
            r_q[k] <= 1'b0;
          for (int k = 0; k < PIPE_STAGES - 2; k++)
            p_q[k] <= '0;
        end else if (adv) begin
          vld    <= {vld[PIPE_STAGES-2:0], xfer_in};
          m_q    <= mag(in_data);
          r_q[0] <= round_en;
          for (int k = 1; k < PIPE_STAGES - 1; k++)
            r_q[k] <= r_q[k-1];
          p_q[0] <= sq(m_q);
          for (int k = 1; k < PIPE_STAGES - 2; k++)
            p_q[k] <= p_q[k-1];
          {out_sat, out_data} <=
            fin(p_q[PIPE_STAGES-3], r_q[PIPE_STAGES-2]);
        end
      end
    end
  endgenerate

  // clear wins over a same-cycle increment; count sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr_stats)
      sat_count <= '0;
    else if (out_valid && out_ready && out_sat && !(&sat_count))
      sat_count <= sat_count + 1'b1;
  end

endmodule

// File: tb/tb_squared_pipe.sv
// tb_squared_pipe: directed checks of squared_pipe across four parameter sets.
// Inputs are shared; each instance's outputs are checked where relevant.
module tb_squared_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [10:0] in_data = '0;
  logic        round_en = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_stats = 1'b0;

  logic        a_rdy, a_valid, a_sat;
  logic [10:0] a_data;
  logic [15:0] a_cnt;
  logic        u_rdy, u_valid, u_sat;
  logic [10:0] u_data;
  logic [15:0] u_cnt;
  logic        c_rdy, c_valid, c_sat;
  logic [10:0] c_data;
  logic [1:0]  c_cnt;
  logic        t_rdy, t_valid, t_sat;
  logic [10:0] t_data;
  logic [15:0] t_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  squared_pipe u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
    .in_data(in_data), .round_en(round_en), .out_valid(a_valid),
    .out_ready(out_ready), .out_data(a_data), .out_sat(a_sat),
    .clr_stats(clr_stats), .sat_count(a_cnt)
  );

  squared_pipe #(.SIGNED_IN(1'b0)) u_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_rdy),
    .in_data(in_data), .round_en(round_en), .out_valid(u_valid),
    .out_ready(out_ready), .out_data(u_data), .out_sat(u_sat),
    .clr_stats(clr_stats), .sat_count(u_cnt)
  );

  squared_pipe #(.CNT_WIDTH(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_rdy),
    .in_data(in_data), .round_en(round_en), .out_valid(c_valid),
    .out_ready(out_ready), .out_data(c_data), .out_sat(c_sat),
    .clr_stats(clr_stats), .sat_count(c_cnt)
  );

  squared_pipe #(.PIPE_STAGES(3)) u_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_rdy),
    .in_data(in_data), .round_en(round_en), .out_valid(t_valid),
    .out_ready(out_ready), .out_data(t_data), .out_sat(t_sat),
    .clr_stats(clr_stats), .sat_count(t_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    vecs++;
    if (a_valid !== 1'b0) begin
      errs++; $display("FAIL rst_valid got %0d want 0", a_valid);
    end
    vecs++;
    if (a_data !== 11'd0 || a_sat !== 1'b0) begin
      errs++; $display("FAIL rst_data got %0d/%0d want 0/0", a_data, a_sat);
    end
    vecs++;
    if (a_cnt !== 16'd0) begin
      errs++; $display("FAIL rst_cnt got %0d want 0", a_cnt);
    end
    vecs++;
    if (a_rdy !== 1'b0) begin
      errs++; $display("FAIL rst_ready got %0d want 0", a_rdy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int vin [4] = '{100, -100, 0, 1023};
    int want [4] = '{19, 19, 0, 2044};
    round_en  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 11'(vin[0]);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c + 1 < 4) in_data = 11'(vin[c+1]);
      else in_valid = 1'b0;
      vecs++;
      if (c >= 1 && c <= 4) begin
        if (a_valid !== 1'b1 || a_data !== 11'(want[c-1]) || a_sat !== 1'b0) begin
          errs++;
          $display("FAIL b2b_out[%0d] got v%0d d%0d s%0d want v1 d%0d s0",
                   c, a_valid, a_data, a_sat, want[c-1]);
        end
      end else if (a_valid !== 1'b0) begin
        errs++; $display("FAIL b2b_bubble[%0d] got %0d want 0", c, a_valid);
      end
      vecs++;
      if (c >= 2) begin
        if (t_valid !== 1'b1 || t_data !== 11'(want[c-2])) begin
          errs++;
          $display("FAIL p3_out[%0d] got v%0d d%0d want v1 d%0d",
                   c, t_valid, t_data, want[c-2]);
        end
      end else if (t_valid !== 1'b0) begin
        errs++; $display("FAIL p3_bubble[%0d] got %0d want 0", c, t_valid);
      end
    end
  endtask

  task automatic test_round;
    round_en = 1'b1;
    in_valid = 1'b1;
    in_data  = 11'd100;
    tick();
    in_data = 11'(-1024);
    tick();
    in_valid = 1'b0;
    vecs++;
    if (a_valid !== 1'b1 || a_data !== 11'd20 || a_sat !== 1'b0) begin
      errs++; $display("FAIL round_100 got v%0d d%0d s%0d want v1 d20 s0",
                       a_valid, a_data, a_sat);
    end
    tick();
    vecs++;
    if (a_valid !== 1'b1 || a_data !== 11'd2047 || a_sat !== 1'b1) begin
      errs++; $display("FAIL round_neg1024 got v%0d d%0d s%0d want v1 d2047 s1",
                       a_valid, a_data, a_sat);
    end
    vecs++;
    if (a_cnt !== 16'd0) begin
      errs++; $display("FAIL cnt_before_xfer got %0d want 0", a_cnt);
    end
    tick();
    vecs++;
    if (a_cnt !== 16'd1) begin
      errs++; $display("FAIL cnt_after_xfer got %0d want 1", a_cnt);
    end
    round_en = 1'b0;
    tick();
  endtask

  task automatic test_unsigned;
    in_valid = 1'b1;
    in_data  = 11'd2047;
    tick();
    in_data = 11'd22;
    tick();
    in_valid = 1'b0;
    vecs++;
    if (u_valid !== 1'b1 || u_data !== 11'd2047 || u_sat !== 1'b1) begin
      errs++; $display("FAIL uns_2047 got v%0d d%0d s%0d want v1 d2047 s1",
                       u_valid, u_data, u_sat);
    end
    vecs++;
    if (a_data !== 11'd0 || a_sat !== 1'b0) begin
      errs++; $display("FAIL sgn_minus1 got d%0d s%0d want d0 s0", a_data, a_sat);
    end
    tick();
    vecs++;
    if (u_valid !== 1'b1 || u_data !== 11'd0 || u_sat !== 1'b0) begin
      errs++; $display("FAIL uns_22 got v%0d d%0d s%0d want v1 d0 s0",
                       u_valid, u_data, u_sat);
    end
    tick();
  endtask

  task automatic test_backpressure;
    int vin [8] = '{100, -100, 0, 1023, -1024, 511, -512, 45};
    int want [8] = '{19, 19, 0, 2044, 2047, 510, 512, 3};
    int i = 0;
    int k = 0;
    bit hold = 1'b0;
    logic [10:0] held_d = '0;
    for (int cyc = 0; cyc < 80 && k < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (i < 8);
      in_data   = (i < 8) ? 11'(vin[i]) : 11'd0;
      #1;
      vecs++;
      if (a_rdy !== (!a_valid || out_ready)) begin
        errs++; $display("FAIL bp_ready[%0d] got %0d want %0d",
                         cyc, a_rdy, (!a_valid || out_ready));
      end
      if (hold) begin
        vecs++;
        if (a_valid !== 1'b1 || a_data !== held_d) begin
          errs++; $display("FAIL bp_hold[%0d] got v%0d d%0d want v1 d%0d",
                           cyc, a_valid, a_data, held_d);
        end
      end
      hold   = a_valid && !out_ready;
      held_d = a_data;
      if (a_valid && out_ready) begin
        vecs++;
        if (a_data !== 11'(want[k])) begin
          errs++; $display("FAIL bp_data[%0d] got %0d want %0d", k, a_data, want[k]);
        end
        k++;
      end
      if (in_valid && a_rdy) i++;
      tick();
    end
    in_valid = 1'b0;
    vecs++;
    if (k != 8) begin
      errs++; $display("FAIL bp_delivered got %0d want 8", k);
    end
    vecs++;
    if (a_valid !== 1'b0) begin
      errs++; $display("FAIL bp_no_dup got %0d want 0", a_valid);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_sat_count;
    int want [5] = '{1, 2, 3, 3, 3};
    out_ready = 1'b1;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    vecs++;
    if (c_cnt !== 2'd0) begin
      errs++; $display("FAIL cnt_clear got %0d want 0", c_cnt);
    end
    in_valid = 1'b1;
    in_data  = 11'(-1024);
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c >= 4) in_valid = 1'b0;
      if (c >= 2) begin
        vecs++;
        if (c_cnt !== 2'(want[c-2])) begin
          errs++; $display("FAIL cnt_sticky[%0d] got %0d want %0d",
                           c - 2, c_cnt, want[c-2]);
        end
      end
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    vecs++;
    if (c_cnt !== 2'd3 || c_valid !== 1'b1 || c_sat !== 1'b1) begin
      errs++; $display("FAIL cnt_pre_clr got c%0d v%0d s%0d want c3 v1 s1",
                       c_cnt, c_valid, c_sat);
    end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    vecs++;
    if (c_cnt !== 2'd0) begin
      errs++; $display("FAIL cnt_clr_wins got %0d want 0", c_cnt);
    end
    tick();
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 11'(-1024);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    vecs++;
    if (a_cnt !== 16'd1) begin
      errs++; $display("FAIL flush_pre_cnt got %0d want 1", a_cnt);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 11'd100;
    tick();
    in_data = 11'(-100);
    tick();
    in_valid = 1'b0;
    tick();
    vecs++;
    if (a_valid !== 1'b1 || a_data !== 11'd19 || a_rdy !== 1'b0) begin
      errs++; $display("FAIL flush_stall got v%0d d%0d r%0d want v1 d19 r0",
                       a_valid, a_data, a_rdy);
    end
    rst = 1'b1;
    tick();
    vecs++;
    if (a_valid !== 1'b0 || a_data !== 11'd0 || a_sat !== 1'b0) begin
      errs++; $display("FAIL flush_out got v%0d d%0d s%0d want v0 d0 s0",
                       a_valid, a_data, a_sat);
    end
    vecs++;
    if (a_cnt !== 16'd0 || a_rdy !== 1'b0) begin
      errs++; $display("FAIL flush_cnt got c%0d r%0d want c0 r0", a_cnt, a_rdy);
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 11'd45;
    tick();
    in_valid = 1'b0;
    vecs++;
    if (a_valid !== 1'b0) begin
      errs++; $display("FAIL flush_lat1 got %0d want 0", a_valid);
    end
    tick();
    vecs++;
    if (a_valid !== 1'b1 || a_data !== 11'd3) begin
      errs++; $display("FAIL flush_new got v%0d d%0d want v1 d3", a_valid, a_data);
    end
    tick();
    vecs++;
    if (a_valid !== 1'b0) begin
      errs++; $display("FAIL flush_drain got %0d want 0", a_valid);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_round();
    test_unsigned();
    test_backpressure();
    test_sat_count();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
